// File: rtl/booth_mul_arbiter.sv
// Radix-2 Booth multiplier shared by two round-robin arbitrated requesters, one iteration per clock.
// Optional op_count/busy_cycles statistics ports are built only when BOOTH_ARB_STATS_EN is defined.
module booth_mul_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req0_m,
  input  logic [WIDTH-1:0]     req0_r,
  input  logic [WIDTH-1:0]     req1_m,
  input  logic [WIDTH-1:0]     req1_r,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          busy_cycles
`endif
);

  localparam int PW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    last_g;
  logic [1:0]              grant;
  logic                    load;
  logic                    id_p0;
  logic signed [WIDTH:0]   a_p0;
  logic signed [PW-1:0]    acc_p0;

  // One Booth iteration: add/subtract the widened multiplicand into the high part, then shift.
  function automatic logic signed [PW-1:0] booth_step(input logic signed [PW-1:0] p,
                                                       input logic signed [WIDTH:0] a);
    logic signed [WIDTH:0]  hi;
    logic signed [PW-1:0]   sum;
    hi = p[PW-1:WIDTH+1];
    case (p[1:0])
      2'b10:   hi = hi - a;
      2'b01:   hi = hi + a;
      default: hi = hi;
    endcase
    sum = {hi, p[WIDTH:0]};
    return sum >>> 1;
  endfunction

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_g ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready   = (rst_n && state == IDLE) ? grant : 2'b00;
  assign load        = |req_ready;
  assign rsp_valid   = rst_n && (state == DONE);
  assign rsp_id      = rsp_valid ? id_p0 : 1'b0;
  assign rsp_product = rsp_valid ? acc_p0[2*WIDTH:1] : '0;

  // Control: FSM, iteration counter and last-grant pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_g <= 1'b1;
    end else begin
      case (state)
        IDLE: if (load) begin
          state  <= BUSY;
          cnt    <= '0;
          last_g <= grant[1];
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand capture on accept, then one Booth step per BUSY cycle
  always_ff @(posedge clk) begin
    if (load) begin
      id_p0  <= grant[1];
      a_p0   <= grant[1] ? {req1_m[WIDTH-1], req1_m} : {req0_m[WIDTH-1], req0_m};
      acc_p0 <= {{(WIDTH+1){1'b0}}, (grant[1] ? req1_r : req0_r), 1'b0};
    end else if (state == BUSY) begin
      acc_p0 <= booth_step(acc_p0, a_p0);
    end
  end

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
      if (state != IDLE) busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: cycle-level reference model plus directed literal checks and random traffic.
// Stats ports are exercised when BOOTH_ARB_STATS_EN is defined.
module tb_booth_mul_arbiter;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [W-1:0]   req0_m = '0, req0_r = '0, req1_m = '0, req1_r = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic [2*W-1:0] rsp_product;
`ifdef BOOTH_ARB_STATS_EN
  logic [15:0]    op_count, busy_cycles;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_m(req0_m), .req0_r(req0_r), .req1_m(req1_m), .req1_r(req1_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product)
`ifdef BOOTH_ARB_STATS_EN
    , .op_count(op_count), .busy_cycles(busy_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 8'(x * y);
  endfunction

  // Reference model: phase 0 idle, 1 computing, 2 holding a response
  int         m_phase = 0;
  int         m_left = 0;
  logic       m_last = 1'b1;
  logic       m_id = 1'b0;
  logic [7:0] m_prod = '0;
  int         m_ops = 0;
  int         m_busy = 0;
  logic [1:0] er;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_id", 32'(rsp_id), 32'(0));
      chk("rst_rsp_product", 32'(rsp_product), 32'(0));
      m_phase = 0; m_last = 1'b1; m_ops = 0; m_busy = 0;
    end else begin
      er = 2'b00;
      if (m_phase == 0) begin
        if (req_valid == 2'b11)      er = m_last ? 2'b01 : 2'b10;
        else                         er = req_valid;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_product", 32'(rsp_product), 32'(m_prod));
      end
`ifdef BOOTH_ARB_STATS_EN
      chk("op_count", 32'(op_count), 32'(m_ops[15:0]));
      chk("busy_cycles", 32'(busy_cycles), 32'(m_busy[15:0]));
`endif
      if (m_phase != 0) m_busy++;
      case (m_phase)
        0: if (er != 2'b00) begin
          m_id    = er[1];
          m_prod  = er[1] ? mul(req1_m, req1_r) : mul(req0_m, req0_r);
          m_last  = er[1];
          m_left  = W;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (rsp_ready) begin
          m_phase = 0;
          m_ops++;
        end
      endcase
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int who, input logic [3:0] m, input logic [3:0] r);
    if (who == 0) begin req0_m = m; req0_r = r; end
    else          begin req1_m = m; req1_r = r; end
    req_valid[who] = 1'b1;
  endtask

  // One request on an otherwise idle unit; expects the response WIDTH+1 cycles after accept.
  task automatic op(input int who, input logic [3:0] m, input logic [3:0] r,
                    input logic [7:0] exp_p, input string tag);
    int lat;
    bit got;
    rsp_ready = 1'b1;
    set_req(who, m, r);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[who]) got = 1;
    end
    chk({tag, "_accept"}, 32'(got), 32'(1));
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_id"}, 32'(rsp_id), 32'(who));
    chk({tag, "_product"}, 32'(rsp_product), 32'(exp_p));
    @(posedge clk); #1;
  endtask

  logic [1:0] acc;
  logic       ids [2];
  logic [7:0] prods [2];
  logic [7:0] hold_p;
  logic       hold_id;
  int         n;
  bit         got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset;
    op(0, 4'd3, 4'd5, 8'h0F, "single");
    op(1, 4'h8, 4'h8, 8'h40, "m8xm8");
    op(0, 4'h8, 4'h7, 8'hC8, "m8x7");
    op(1, 4'h7, 4'hF, 8'hF9, "7xm1");
    op(0, 4'h0, 4'h8, 8'h00, "0xm8");

    // Simultaneous requests straight after reset
    do_reset;
    req0_m = 4'd2; req0_r = 4'd3; req1_m = 4'hD; req1_r = 4'd4; req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_ready == 2'b11) chk("sim_ready_onehot", 32'(req_ready), 32'(0));
      if (rsp_valid) begin
        ids[n] = rsp_id; prods[n] = rsp_product; n++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    chk("sim_count", 32'(n), 32'(2));
    chk("sim_first_id", 32'(ids[0]), 32'(0));
    chk("sim_first_product", 32'(prods[0]), 32'(8'h06));
    chk("sim_second_id", 32'(ids[1]), 32'(1));
    chk("sim_second_product", 32'(prods[1]), 32'(8'hF4));
    req_valid = 2'b00;

    // Backpressure in the response phase
    rsp_ready = 1'b0;
    set_req(0, 4'd6, 4'd3);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (rsp_valid) got = 1;
      else begin
        @(posedge clk); #1;
        req_valid = req_valid & ~acc;
      end
    end
    chk("bp_response_seen", 32'(got), 32'(1));
    hold_p = rsp_product; hold_id = rsp_id;
    chk("bp_product", 32'(hold_p), 32'(8'h12));
    chk("bp_id", 32'(hold_id), 32'(0));
    @(posedge clk); #1;
    set_req(0, 4'd1, 4'd1); set_req(1, 4'd2, 4'd2);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
      chk("bp_hold_product", 32'(rsp_product), 32'(hold_p));
      chk("bp_hold_ready", 32'(req_ready), 32'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("bp_valid_until_edge", 32'(rsp_valid), 32'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_back_to_idle", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;

    // Reset during the second computing cycle
    set_req(0, 4'd5, 4'd3);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    chk("mid_rst_accept", 32'(got), 32'(1));
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("mid_rst_rsp_product", 32'(rsp_product), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_no_response", 32'(rsp_valid), 32'(0));
    end
    @(posedge clk); #1;
    op(0, 4'hF, 4'hF, 8'h01, "after_rst");

    // Random traffic checked by the reference model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 4'($urandom), 4'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    do_reset;
`ifdef BOOTH_ARB_STATS_EN
    op(0, 4'd1, 4'd2, 8'h02, "stats_a");
    op(1, 4'hE, 4'd3, 8'hFA, "stats_b");
    op(0, 4'd7, 4'd7, 8'h31, "stats_c");
    chk("stats_op_count", 32'(op_count), 32'(3));
    chk("stats_busy_cycles", 32'(busy_cycles), 32'(15));
`else
    op(1, 4'd7, 4'd7, 8'h31, "final");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
